// File: rtl/ballot_collector_if.sv
// Voter-facing bus of the ballot collector: raw buttons and round control in,
// the latched ballot and round status out.
interface ballot_collector_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       vote_btn;
    logic             start;
    logic             close;
    logic [3:0]       ballot;
    logic             ballot_valid;
    logic             round_open;
    logic [3:0]       voted;
    logic [CNT_W-1:0] round_cnt;

    modport master (
        output vote_btn, start, close,
        input  ballot, ballot_valid, round_open, voted, round_cnt
    );

    modport slave (
        input  vote_btn, start, close,
        output ballot, ballot_valid, round_open, voted, round_cnt
    );
endinterface

// File: rtl/ballot_collector.sv
// Conditions four voter pushbuttons and runs a timed voting round, presenting
// the closed-round ballot with a one-cycle valid strobe.
module ballot_collector #(
    parameter int DEBOUNCE = 16,
    parameter int WINDOW   = 1000,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    ballot_collector_if.slave bus
);
    localparam int DB_W  = $clog2(DEBOUNCE);
    localparam int WIN_W = $clog2(WINDOW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OPEN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [3:0]       sync1, sync2;
    logic [3:0]       deb;
    logic [3:0]       press;
    logic [DB_W-1:0]  deb_cnt [4];
    logic [1:0]       state;
    logic [WIN_W-1:0] win_cnt;
    logic [3:0]       votes;
    logic [CNT_W-1:0] round_q;
    logic [3:0]       new_votes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.vote_btn;
            sync2 <= sync1;
        end
    end

    // The debounced level only follows the synchroniser after DEBOUNCE
    // consecutive disagreeing cycles; a rising toggle emits one press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb   <= '0;
            press <= '0;
            for (int k = 0; k < 4; k++) deb_cnt[k] <= '0;
        end else begin
            press <= '0;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DB_W'(DEBOUNCE - 1)) begin
                    deb[k]     <= sync2[k];
                    press[k]   <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    assign new_votes = press & ~votes;

    // A voter's ballot bit and voted flag are set together and only ever
    // cleared together, so one register serves both outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
            votes   <= '0;
            round_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        votes   <= '0;
                        win_cnt <= '0;
                        state   <= OPEN;
                    end
                end
                OPEN: begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    votes   <= votes | new_votes;
                    if (bus.close || win_cnt == WIN_W'(WINDOW - 1)) begin
                        state   <= DONE;
                        round_q <= round_q + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ballot       = votes;
    assign bus.voted        = votes;
    assign bus.round_open   = (state == OPEN);
    assign bus.ballot_valid = (state == DONE);
    assign bus.round_cnt    = round_q;
endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector with DEBOUNCE=4, WINDOW=50, CNT_W=8.
module tb_ballot_collector;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   valid_cnt;

    ballot_collector_if #(.CNT_W(8)) bus ();

    ballot_collector #(
        .DEBOUNCE(4),
        .WINDOW  (50),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // obs packs {ballot, voted, round_open, ballot_valid}
    logic [9:0] obs;
    assign obs = {bus.ballot, bus.voted, bus.round_open, bus.ballot_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ballot_valid === 1'b1) valid_cnt++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_obs(input string name, input logic [9:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s obs=%b expected=%b", name, obs, expv);
        end
    endtask

    task automatic check_cnt(input string name, input logic [7:0] expv);
        checks++;
        if (bus.round_cnt !== expv) begin
            errors++;
            $display("[TB] FAIL %s round_cnt=%0d expected=%0d", name, bus.round_cnt, expv);
        end
    endtask

    task automatic check_pulses(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s valid_pulses=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.vote_btn = 4'b1111;
        bus.start = 1'b1;
        tick(3);
        check_obs("reset_outputs", 10'b0000_0000_0_0);
        check_cnt("reset_round_cnt", 8'd0);
        check_pulses("reset_no_valid", valid_cnt, 0);
        bus.vote_btn = 4'b0000;
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check_obs("reset_release_idle", 10'b0000_0000_0_0);
    endtask

    task automatic test_basic;
        int p0;
        p0 = valid_cnt;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check_obs("basic_open", 10'b0000_0000_1_0);
        bus.vote_btn = 4'b0101;
        tick(8);
        bus.vote_btn = 4'b0000;
        check_obs("basic_votes_mid", 10'b0101_0101_1_0);
        tick(12);
        bus.close = 1'b1;
        tick(1);
        bus.close = 1'b0;
        check_obs("basic_done", 10'b0101_0101_0_1);
        check_cnt("basic_round_cnt", 8'd1);
        tick(1);
        check_obs("basic_idle_hold", 10'b0101_0101_0_0);
        check_pulses("basic_one_pulse", valid_cnt - p0, 1);
    endtask

    task automatic test_timeout;
        int p0;
        p0 = valid_cnt;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(49);
        check_obs("timeout_still_open", 10'b0000_0000_1_0);
        tick(1);
        check_obs("timeout_done", 10'b0000_0000_0_1);
        check_cnt("timeout_round_cnt", 8'd2);
        tick(1);
        check_obs("timeout_idle", 10'b0000_0000_0_0);
        check_pulses("timeout_one_pulse", valid_cnt - p0, 1);
    endtask

    task automatic test_bounce;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.vote_btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
        end
        bus.vote_btn = 4'b0000;
        tick(4);
        check_obs("bounce_no_vote", 10'b0000_0000_1_0);
        bus.vote_btn = 4'b1000;
        tick(8);
        check_obs("repeat_first_press", 10'b1000_1000_1_0);
        bus.vote_btn = 4'b0000;
        tick(8);
        bus.vote_btn = 4'b1000;
        tick(8);
        check_obs("repeat_second_press", 10'b1000_1000_1_0);
        bus.vote_btn = 4'b0000;
        tick(6);
        bus.close = 1'b1;
        tick(1);
        bus.close = 1'b0;
        check_obs("repeat_done", 10'b1000_1000_0_1);
        check_cnt("repeat_round_cnt", 8'd3);
        tick(8);
    endtask

    task automatic test_edge_close;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        bus.vote_btn = 4'b0010;
        tick(6);
        check_obs("edge_before_close", 10'b0000_0000_1_0);
        bus.close = 1'b1;
        tick(1);
        bus.close = 1'b0;
        check_obs("edge_vote_with_close", 10'b0010_0010_0_1);
        check_cnt("edge_round_cnt", 8'd4);
        bus.vote_btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_idle_press;
        check_obs("idle_holds_ballot", 10'b0010_0010_0_0);
        bus.vote_btn = 4'b0100;
        tick(10);
        check_obs("idle_press_ignored", 10'b0010_0010_0_0);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(5);
        bus.close = 1'b1;
        tick(1);
        bus.close = 1'b0;
        check_obs("idle_press_not_queued", 10'b0000_0000_0_1);
        bus.vote_btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_mid_reset;
        int p0;
        p0 = valid_cnt;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.vote_btn = 4'b1001;
        tick(8);
        check_obs("midreset_votes", 10'b1001_1001_1_0);
        rst_n = 1'b0;
        bus.vote_btn = 4'b0000;
        tick(2);
        check_obs("midreset_cleared", 10'b0000_0000_0_0);
        check_cnt("midreset_round_cnt", 8'd0);
        rst_n = 1'b1;
        tick(60);
        check_obs("midreset_stays_idle", 10'b0000_0000_0_0);
        check_pulses("midreset_no_pulse", valid_cnt - p0, 0);
    endtask

    task automatic test_wrap;
        int p0;
        p0 = valid_cnt;
        for (int r = 1; r <= 256; r++) begin
            bus.start = 1'b1;
            tick(1);
            bus.start = 1'b0;
            bus.close = 1'b1;
            tick(1);
            bus.close = 1'b0;
            tick(1);
            if (r == 128) check_cnt("wrap_half", 8'd128);
            if (r == 255) check_cnt("wrap_all_ones", 8'd255);
        end
        check_cnt("wrap_to_zero", 8'd0);
        check_pulses("wrap_pulses", valid_cnt - p0, 256);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        valid_cnt = 0;
        rst_n = 1'b0;
        bus.vote_btn = 4'b0000;
        bus.start = 1'b0;
        bus.close = 1'b0;
        tick(1);
        test_reset();
        test_basic();
        test_timeout();
        test_bounce();
        test_edge_close();
        test_idle_press();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Upstream stage of the 4-voter decision block. Captures four asynchronous voter pushbuttons and runs a timed voting round.
- Conditions each button with a synchroniser and debounce, then latches one vote per voter per round.
- Presents the closed-round 4-bit ballot vector, held stable, to the voter decoder's 4-bit input, together with a one-cycle valid strobe.

Parameters:
- DEBOUNCE, 16: consecutive synchronised cycles a button level must persist before the debounced level changes (>=2).
- WINDOW, 1000: maximum length of an open round in clock cycles (>=2).
- CNT_W, 8: width of the round counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- vote_btn  input  4  raw asynchronous voter buttons; bit k = voter k, 1 = pressed.
- start  input  1  opens a round; sampled only in IDLE.
- close  input  1  closes an open round early; sampled only in OPEN.
- ballot  output  4  latched votes; feeds the voter decoder input.
- ballot_valid  output  1  one-cycle pulse when ballot is final.
- round_open  output  1  high while in OPEN.
- voted  output  4  per-voter "vote already cast this round" flags.
- round_cnt  output  CNT_W  number of completed rounds.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; ballot=0, ballot_valid=0, round_open=0, voted=0, round_cnt=0.
  - Synchronisers, debounced levels and all counters cleared.
  - Reset wins over every other input, including mid-round; any partial ballot is discarded and no valid pulse is issued.
- Conditioning, per bit:
  - 2-flop synchroniser feeds a debounce counter.
  - The counter increments while the synchronised level differs from the debounced level, and clears when they are equal.
  - When the count reaches DEBOUNCE-1 and the levels still differ, the debounced level toggles and the counter clears.
  - A press event is a one-cycle pulse on the debounced rising edge.
  - Glitches shorter than DEBOUNCE cycles produce no event.
  - Latency from a clean raw rise to the voted bit reading 1 is between DEBOUNCE+2 and DEBOUNCE+4 cycles.
  - Releases produce no event.
- State machine: IDLE -> OPEN -> DONE -> IDLE.
  - IDLE:
    - round_open=0. ballot and voted hold their last values.
    - If start=1: clear ballot, voted and the window counter; go to OPEN next cycle.
  - OPEN:
    - round_open=1; the window counter increments every cycle.
    - A press event on bit k with voted[k]=0 sets ballot[k]=1 and voted[k]=1. Later presses by the same voter are ignored (one vote per round).
    - If close=1, or the window counter equals WINDOW-1, go to DONE.
    - A press event in the same cycle as the closing condition is still counted.
    - start is ignored in OPEN.
  - DONE (exactly 1 cycle):
    - ballot_valid=1, round_open=0, ballot stable.
    - round_cnt increments, wrapping from all-ones to 0.
    - Always returns to IDLE; start is ignored in DONE.
- Voters who did not press are recorded as ballot[k]=0.
- ballot changes only in OPEN, on start, or on reset. It stays valid from DONE until the next start.
- Presses while in IDLE or DONE are discarded; they are not queued for the next round.
- Simultaneous close and window expiry produce a single DONE.
- Maximum round length: WINDOW cycles in OPEN, then 1 cycle in DONE.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with vote_btn=4'b1111 and start=1 -> all outputs 0, state IDLE, no ballot_valid pulse.
- Basic round (DEBOUNCE=4, WINDOW=50): start; press bits 0 and 2 cleanly; close at cycle 20 -> ballot=4'b0101, voted=4'b0101, one ballot_valid pulse, round_cnt=1.
- Timeout: start with no presses and no close -> ballot_valid exactly 50 cycles after OPEN entry, ballot=4'b0000, round_cnt increments.
- Bounce and repeat votes:
  - Bit 1 toggles every cycle for 10 cycles, then settles low -> no vote recorded.
  - Bit 3 is pressed, released and pressed again -> ballot[3]=1, and voted[3] set once only.
- Edge timing:
  - Press on bit 1 whose event lands in the same cycle as close -> ballot[1]=1.
  - Press during IDLE followed by start -> ballot=0 at the next close.
- Mid-round reset and wrap:
  - Assert rst_n=0 during OPEN with 2 votes cast -> all outputs clear, no valid pulse.
  - Run 256 rounds with CNT_W=8 -> round_cnt wraps to 0.
